// File: rtl/multislice_sequential_adder.sv
// multislice_sequential_adder: wide unsigned adder that reuses one CLA slice per cycle, LSB slice first.
module behave_4bit_carry_lookahead_adder_parameter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  logic [WIDTH-1:0] w_g, w_p;
  logic [WIDTH:0]   w_c;
  assign w_g = A & B;
  assign w_p = A ^ B;
  always_comb begin
    w_c[0] = Cin;
    for (int i = 0; i < WIDTH; i++) w_c[i+1] = w_g[i] | (w_p[i] & w_c[i]);
  end
  assign Sum  = w_p ^ w_c[WIDTH-1:0];
  assign Cout = w_c[WIDTH];
endmodule

module multislice_sequential_adder #(
  parameter int SLICE_W    = 8,
  parameter int NUM_SLICES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [SLICE_W*NUM_SLICES-1:0] A,
  input  logic [SLICE_W*NUM_SLICES-1:0] B,
  input  logic                          Cin,
  output logic                          busy,
  output logic                          done,
  output logic [SLICE_W*NUM_SLICES-1:0] Sum,
  output logic                          Cout
);
  localparam int TOTAL_W = SLICE_W * NUM_SLICES;
  localparam int CW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state, w_next;
  logic [TOTAL_W-1:0] r_opa, r_opb, r_acc, w_acc;
  logic               r_carry, w_cout;
  logic [CW-1:0]      r_cnt;
  logic [SLICE_W-1:0] w_sum;
  behave_4bit_carry_lookahead_adder_parameter #(.WIDTH(SLICE_W)) u_slice (
    .A(r_opa[SLICE_W-1:0]),
    .B(r_opb[SLICE_W-1:0]),
    .Cin(r_carry),
    .Sum(w_sum),
    .Cout(w_cout)
  );
  // accumulator with the current slice merged in, so the final edge can publish it directly
  always_comb begin
    w_acc = r_acc;
    w_acc[r_cnt*SLICE_W +: SLICE_W] = w_sum;
  end
  always_comb begin
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (r_cnt == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_opa   <= A;
      r_opb   <= B;
      r_carry <= Cin;
      r_cnt   <= '0;
    end else if (r_state == RUN) begin
      r_acc   <= w_acc;
      r_carry <= w_cout;
      r_opa   <= r_opa >> SLICE_W;
      r_opb   <= r_opb >> SLICE_W;
      r_cnt   <= r_cnt == LAST ? r_cnt : r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        Sum  <= w_acc;
        Cout <= w_cout;
      end
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
endmodule

// File: tb/tb_multislice_sequential_adder.sv
// tb_multislice_sequential_adder: scoreboard bench for the 4x8 adder plus a 1x8 instance.
module tb_multislice_sequential_adder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, Cin = 1'b0;
  logic [31:0] A = '0, B = '0, Sum;
  logic        busy, done, Cout;
  logic        start1 = 1'b0, cin1 = 1'b0;
  logic [7:0]  a1 = '0, b1 = '0, sum1;
  logic        busy1, done1, cout1;
  int          n_tests = 0, n_fail = 0;
  logic [32:0] q0[$];
  logic [8:0]  q1[$];
  logic [32:0] last = '0;

  multislice_sequential_adder #(.SLICE_W(8), .NUM_SLICES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
  );
  multislice_sequential_adder #(.SLICE_W(8), .NUM_SLICES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .Sum(sum1), .Cout(cout1)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q0.size() == 0) chk("unexpected_done", 1, 0);
      else chk("result", {31'b0, Cout, Sum}, {31'b0, q0.pop_front()});
    end
    if (rst_n && done1) begin
      if (q1.size() == 0) chk("unexpected_done1", 1, 0);
      else chk("result1", {55'b0, cout1, sum1}, {55'b0, q1.pop_front()});
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic c, input logic [32:0] e);
    int cyc, nbusy;
    A = a; B = b; Cin = c; start = 1'b1;
    q0.push_back(e);
    @(negedge clk);
    start = 1'b0; cyc = 1; nbusy = busy;
    chk("hold", {31'b0, Cout, Sum}, {31'b0, last});
    while (!done && cyc < 20) begin
      A = $urandom; B = $urandom; Cin = 1'($urandom);
      @(negedge clk);
      cyc++;
      nbusy += busy;
    end
    chk("latency", cyc, 5);
    chk("busy_cycles", nbusy, 5);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("busy_idle", busy, 0);
    last = e;
  endtask

  initial begin
    int cyc;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", {Cout, Sum}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'h000000B7, 32'h000000D0, 1'b0, {1'b0, 32'h00000187});
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, {1'b1, 32'h00000000});
    issue(32'h12345678, 32'h9ABCDEF0, 1'b1, {1'b0, 32'hACF13569});
    issue(32'h80000000, 32'h80000000, 1'b0, {1'b1, 32'h00000000});
    // start held high: only the edges that see IDLE may capture operands
    A = 32'h11111111; B = 32'h22222222; Cin = 1'b0; start = 1'b1;
    q0.push_back({1'b0, 32'h33333333});
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      chk("held_done", done, n == 5 || n == 11);
      if (n == 6) begin
        A = 32'hFFFF0000; B = 32'h00010000; Cin = 1'b1;
        q0.push_back({1'b1, 32'h00000001});
      end else begin
        A = $urandom; B = $urandom; Cin = 1'($urandom);
      end
      if (n == 12) start = 1'b0;
    end
    chk("held_sum", {Cout, Sum}, {1'b1, 32'h00000001});
    A = 32'h01010101; B = 32'h01010101; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum", {Cout, Sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    last = '0;
    issue(32'h00FF00FF, 32'h00010001, 1'b0, {1'b0, 32'h01000100});
    a1 = 8'hF0; b1 = 8'hF0; cin1 = 1'b0; start1 = 1'b1;
    q1.push_back({1'b1, 8'hE0});
    @(negedge clk);
    start1 = 1'b0; cyc = 1;
    chk("busy1", busy1, 1);
    while (!done1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency1", cyc, 2);
    @(negedge clk);
    chk("done1_width", done1, 0);
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
